// File: rtl/mesh_term_ingress_if.sv
// -----------------------------------------------------------------------------
// mesh_term_ingress_if
// Bundle of the source-side and router-side signals of one terminal ingress
// buffer.
//
// Handshake semantics:
//   - Source side: push is a one-cycle write strobe that goes with data_in.
//     While full is high a push is refused (dropped) unless the router pops in
//     the same cycle.
//   - Router side: the buffer is first-word-fall-through. pndng_i_in acts as
//     "valid" and data_out_i_in carries the head. popin acts as "ready". The
//     head is consumed on a rising edge where popin && pndng_i_in.
//     popin while pndng_i_in is low has no effect.
//
// Modports:
//   master : the environment. It drives push/data_in/popin and observes the
//            status outputs.
//   slave  : the buffer itself.
//
// Parameters:
//   PCKG_SZ  packet width in bits
//   CNT_W    occupancy counter width, $clog2(fifo_depth+1)
// -----------------------------------------------------------------------------
interface mesh_term_ingress_if #(
  parameter int PCKG_SZ = 20,
  parameter int CNT_W   = 3
);
  logic               push;
  logic [PCKG_SZ-1:0] data_in;
  logic               full;
  logic               pndng_i_in;
  logic [PCKG_SZ-1:0] data_out_i_in;
  logic               popin;
  logic [CNT_W-1:0]   count;
  logic [15:0]        drop_cnt;
  logic [15:0]        bad_cnt;

  modport master (
    output push, data_in, popin,
    input  full, pndng_i_in, data_out_i_in, count, drop_cnt, bad_cnt
  );

  modport slave (
    input  push, data_in, popin,
    output full, pndng_i_in, data_out_i_in, count, drop_cnt, bad_cnt
  );
endinterface

// File: rtl/mesh_term_ingress.sv
// -----------------------------------------------------------------------------
// mesh_term_ingress
// Per-terminal ingress buffer that sits directly upstream of one mesh router
// terminal input port.
//   - A source writes packets with push, and full provides backpressure.
//   - The router sees the oldest packet first-word-fall-through and consumes
//     it with popin.
//   - The buffer also keeps saturating counters of refused packets (drop_cnt)
//     and of header-rejected packets (bad_cnt).
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high. It clears the pointers, the occupancy
//            and both counters. Buffered packets are discarded.
//   bus    : mesh_term_ingress_if.slave, which carries:
//              push, data_in, full, pndng_i_in, data_out_i_in, popin,
//              count, drop_cnt, bad_cnt
//
// Packet layout (MSB first):
//   Nxt_jump[8], id_row[4], id_colum[4], mode[1], payload
//
// Build option:
//   MESH_INGRESS_HDR_CHECK_EN
//     When defined, a push whose {id_row,id_colum} is neither bdcst nor inside
//     the ROWS x COLUMS mesh is rejected and counted in bad_cnt.
//     When undefined, every packet is eligible and bad_cnt is tied to zero.
// -----------------------------------------------------------------------------
module mesh_term_ingress #(
  parameter int         ROWS       = 2,
  parameter int         COLUMS     = 2,
  parameter int         pckg_sz    = 20,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] bdcst      = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  mesh_term_ingress_if.slave    bus
);

  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW = $clog2(fifo_depth + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(fifo_depth - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(fifo_depth);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  // ---------------------------------------------------------------------------
  // Header decode
  // ---------------------------------------------------------------------------
  logic [3:0] id_row;
  logic [3:0] id_colum;
  logic       hdr_ok;

  assign id_row   = bus.data_in[pckg_sz-9  -: 4];
  assign id_colum = bus.data_in[pckg_sz-13 -: 4];

  // A broadcast destination is always legal. Otherwise the destination must
  // address a terminal inside the mesh.
  assign hdr_ok = ({id_row, id_colum} == bdcst) ||
                  ((int'(id_row) < ROWS) && (int'(id_colum) < COLUMS));

  logic eligible;

`ifdef MESH_INGRESS_HDR_CHECK_EN
  assign eligible = hdr_ok;
`else
  logic unused_hdr_ok;
  assign eligible      = 1'b1;
  assign unused_hdr_ok = hdr_ok;
`endif

  // ---------------------------------------------------------------------------
  // Transfer decisions
  // ---------------------------------------------------------------------------
  logic is_empty;
  logic is_full;
  logic do_pop;
  logic do_push;
  logic do_drop;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  // A pop frees a slot in the same cycle, so a push into a full buffer still
  // fits when the router pops alongside it. A pop is only meaningful when
  // something is stored, so an empty buffer ignores popin.
  assign do_pop  = bus.popin && !is_empty;
  assign do_push = bus.push && eligible && (!is_full || do_pop);
  assign do_drop = bus.push && eligible && is_full && !do_pop;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;

    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end

    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (do_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // The storage array has no reset. Its contents are only observable through
  // rd_ptr while count is non-zero, and count is reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Header-reject counter
  // ---------------------------------------------------------------------------
`ifdef MESH_INGRESS_HDR_CHECK_EN
  logic [15:0] bad_cnt_q, bad_cnt_d;
  logic        do_bad;

  // A rejected header is counted here only. It never also counts as a drop,
  // even when the buffer is full.
  assign do_bad = bus.push && !hdr_ok;

  always_comb begin
    bad_cnt_d = bad_cnt_q;
    if (do_bad && (bad_cnt_q != 16'hFFFF)) begin
      bad_cnt_d = bad_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_cnt_q <= '0;
    end else begin
      bad_cnt_q <= bad_cnt_d;
    end
  end

  assign bus.bad_cnt = bad_cnt_q;
`else
  assign bus.bad_cnt = 16'd0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // All outputs are decoded from registers only, so they clear as soon as the
  // asynchronous reset asserts. A popped slot is never shown: when the buffer
  // is empty the output is forced to zero.
  assign bus.full          = is_full;
  assign bus.pndng_i_in    = !is_empty;
  assign bus.data_out_i_in = is_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.count         = count_q;
  assign bus.drop_cnt      = drop_cnt_q;

endmodule
